// File: rtl/instr_fetch_prefetch.sv
// Instruction-fetch front end: PC owner, single-outstanding memory requester and prefetch FIFO.
// Optional counters are compiled in when FETCH_STATS_EN is defined.
module instr_fetch_prefetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [63:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed,
  output logic [31:0] stat_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ISSUE, WAIT, DISCARD} state_t;

  state_t          state_reg, state_next;
  logic [63:0]     pc_reg, pc_next;
  logic [63:0]     req_pc_reg;
  logic [CW-1:0]   count_reg;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [31:0]     instr_mem [DEPTH];
  logic [63:0]     pc_mem    [DEPTH];

  logic grant, push, pop, dropped;

  // Slot reservation is implicit: requests only leave ISSUE, where nothing is outstanding.
  assign imem_req    = !reset && (state_reg == ISSUE) && (count_reg < CW'(DEPTH)) && !redirect_valid;
  assign imem_addr   = pc_reg;
  assign instr_valid = !reset && (count_reg != '0);
  assign instruction = instr_mem[rd_ptr_reg];
  assign instr_pc    = pc_mem[rd_ptr_reg];

  assign grant   = imem_req && imem_gnt;
  assign push    = (state_reg == WAIT) && imem_rvalid && !redirect_valid;
  assign pop     = instr_valid && instr_ready && !redirect_valid;
  assign dropped = imem_rvalid && (((state_reg == WAIT) && redirect_valid) || (state_reg == DISCARD));

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      ISSUE: begin
        if (grant) begin
          state_next = WAIT;
          pc_next    = pc_reg + 64'd4;
        end
      end
      WAIT: begin
        if (imem_rvalid)         state_next = ISSUE;
        else if (redirect_valid) state_next = DISCARD;
      end
      DISCARD: begin
        if (imem_rvalid) state_next = ISSUE;
      end
      default: state_next = ISSUE;
    endcase
    if (redirect_valid) pc_next = redirect_pc & ~64'h3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ISSUE;
      pc_reg     <= RESET_PC & ~64'h3;
      req_pc_reg <= '0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (grant) req_pc_reg <= pc_reg;
      if (redirect_valid) begin
        // Flush: read pointer catches up with write pointer, discarding every entry.
        count_reg  <= '0;
        rd_ptr_reg <= wr_ptr_reg;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]    <= req_pc_reg;
    end
  end

`ifdef FETCH_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [31:0] flush_inc;
  assign flush_inc = (redirect_valid ? 32'(count_reg) : 32'd0) + (dropped ? 32'd1 : 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
      stat_stall   <= '0;
    end else begin
      if (pop) stat_fetched <= sat_add(stat_fetched, 32'd1);
      stat_flushed <= sat_add(stat_flushed, flush_inc);
      if (instr_ready && !instr_valid) stat_stall <= sat_add(stat_stall, 32'd1);
    end
  end
`else
  logic unused_dropped;
  assign unused_dropped = dropped;
`endif

endmodule

// File: tb/tb_instr_fetch_prefetch.sv
// Scoreboard bench for instr_fetch_prefetch: a behavioural memory plus an expected-instruction queue.
module tb_instr_fetch_prefetch;
  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        reset = 1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 0;
  logic        imem_rvalid = 0;
  logic [31:0] imem_rdata = 0;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        instr_ready = 0;
  logic        redirect_valid = 0;
  logic [63:0] redirect_pc = 0;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed, stat_stall;
`endif

  instr_fetch_prefetch #(.RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;
  ent_t q[$];

  int n_checks = 0;
  int n_errs   = 0;

  // Stimulus knobs
  logic        rst_drv = 1, ready_drv = 0, redir_drv = 0, rand_ready = 0;
  logic [63:0] redir_tgt = 0;
  int          gnt_pct = 100, lat_cfg = 1;

  // Model state
  logic [63:0] model_pc = 0, mem_addr = 0, last_grant_addr = 0;
  logic        outst = 0, mem_busy = 0, mem_drop = 0;
  int          mem_lat = 0, grants = 0;
  int          m_fetched = 0, m_flushed = 0, m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h0050_0093;
    if (a == 64'h4) return 32'h00A0_0113;
    return a[31:0] ^ a[63:32] ^ 32'hC3C3_0001;
  endfunction

  task automatic step();
    logic rv, exp_req;
    ent_t e;
    @(negedge clk);
    rv = 0;
    imem_rvalid = 0;
    if (mem_busy) begin
      if (mem_lat == 0) begin
        rv = 1;
        imem_rvalid = 1;
        imem_rdata = mem_word(mem_addr);
      end else mem_lat--;
    end
    if (!rv) imem_rdata = $urandom;
    imem_gnt       = !mem_busy && ($urandom_range(99) < gnt_pct);
    instr_ready    = rand_ready ? ($urandom_range(99) < 70) : ready_drv;
    redirect_valid = redir_drv;
    redirect_pc    = redir_tgt;
    reset          = rst_drv;
    #1;
    if (reset) begin
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      q.delete();
      outst = 0;
      model_pc = 0;
      if (rv) mem_busy = 0;
      m_fetched = 0; m_flushed = 0; m_stall = 0;
    end else begin
      exp_req = !outst && (q.size() < DEPTH) && !redirect_valid;
      chk("req", imem_req, exp_req);
      chk("valid", instr_valid, q.size() != 0);
      if (instr_ready && !instr_valid) m_stall++;
      if (instr_valid && instr_ready && !redirect_valid && q.size() > 0) begin
        e = q.pop_front();
        chk("pop_pc", instr_pc, e.pc);
        chk("pop_ins", instruction, 64'(e.ins));
        m_fetched++;
        $display("pop pc=%h ins=%h", instr_pc, instruction);
      end
      if (rv) begin
        mem_busy = 0;
        if (outst) begin
          outst = 0;
          if (!mem_drop && !redirect_valid) begin
            e.pc = mem_addr;
            e.ins = mem_word(mem_addr);
            q.push_back(e);
          end else m_flushed++;
        end
      end
      if (redirect_valid) begin
        m_flushed += q.size();
        q.delete();
        model_pc = redirect_pc & ~64'h3;
        if (outst) mem_drop = 1;
      end
      if (imem_req && imem_gnt) begin
        chk("grant_addr", imem_addr, model_pc);
        last_grant_addr = imem_addr;
        outst = 1; mem_busy = 1; mem_drop = 0;
        mem_addr = model_pc;
        mem_lat = (lat_cfg == 0) ? $urandom_range(3) : lat_cfg - 1;
        model_pc = model_pc + 64'd4;
        grants++;
      end
    end
    redir_drv = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int k, g0;
    // Reset for two cycles
    run(2);
    rst_drv = 0;
    // Fill the FIFO with the datapath stalled
    ready_drv = 0; lat_cfg = 1; gnt_pct = 100;
    k = 0;
    while (grants < 4 && k < 50) begin step(); k++; end
    run(12);
    chk("full_grants", grants, 4);
    chk("full_qsize", q.size(), 4);
    ready_drv = 1; step(); ready_drv = 0;
    run(10);
    chk("one_pop_one_req", grants, 5);
    // Stream
    ready_drv = 1;
    run(20);
    // Redirect while a response is outstanding
    lat_cfg = 3;
    k = 0;
    while (!(outst && mem_lat > 0) && k < 50) begin step(); k++; end
    chk("wait_outst", k < 50, 1);
    redir_drv = 1; redir_tgt = 64'h1002;
    g0 = grants;
    step();
    k = 0;
    while (grants == g0 && k < 50) begin step(); k++; end
    chk("redir_addr", last_grant_addr, 64'h1000);
    run(12);
    // Redirect + pop + rvalid in one cycle
    ready_drv = 0;
    k = 0;
    while (!(q.size() >= 1 && mem_busy && outst && mem_lat == 0) && k < 80) begin step(); k++; end
    chk("sim_setup", k < 80, 1);
    redir_drv = 1; redir_tgt = 64'h2000; ready_drv = 1;
    g0 = grants;
    step();
    chk("sim_empty", q.size(), 0);
    k = 0;
    while (grants == g0 && k < 50) begin step(); k++; end
    chk("sim_addr", last_grant_addr, 64'h2000);
    run(10);
    // Reset in the middle of an outstanding fetch
    lat_cfg = 4;
    k = 0;
    while (!(outst && mem_lat >= 2) && k < 50) begin step(); k++; end
    chk("rst_setup", k < 50, 1);
    rst_drv = 1; step(); rst_drv = 0;
    g0 = grants;
    k = 0;
    while (grants == g0 && k < 50) begin step(); k++; end
    chk("rst_addr", last_grant_addr, 64'h0);
    run(15);
    // Random traffic with occasional redirects
    lat_cfg = 0; gnt_pct = 60; rand_ready = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 3) begin
        redir_drv = 1;
        redir_tgt = {32'h0, $urandom};
      end
      step();
    end
    rand_ready = 0; ready_drv = 1;
    run(20);
`ifdef FETCH_STATS_EN
    chk("stat_fetched", stat_fetched, m_fetched);
    chk("stat_flushed", stat_flushed, m_flushed);
    chk("stat_stall", stat_stall, m_stall);
`endif
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
